serdesphy_tx_framer: RTL



---
 rtl/serdesphy_pcs_pkg.sv | 57 +++++
 rtl/serdesphy_prbs7_gen.sv | 37 +++
 rtl/serdesphy_tx_framer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/serdesphy_pcs_pkg.sv
// ----------------------------------------------------------------------------
// serdesphy_pcs_pkg
//   Shared definitions for the SerDes PHY PCS line-coding logic: the TX framer
//   state encoding, the 4b5b control symbols, the 4b5b data encoder and the
//   PRBS7 feedback taps. Used by the TX framer and by the PRBS generator, which
//   the RX checker also instantiates.
// ----------------------------------------------------------------------------
package serdesphy_pcs_pkg;

    // Framer states. Everything between SSD_J and ESD_R is an open burst.
    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_IDLE,
        ST_SSD_J,
        ST_SSD_K,
        ST_DATA,
        ST_ESD_T,
        ST_ESD_R,
        ST_PRBS
    } tx_state_e;

    // Control symbols; bit 4 goes on the line first.
    localparam logic [4:0] SYM_IDLE = 5'b11111;
    localparam logic [4:0] SYM_J    = 5'b11000;
    localparam logic [4:0] SYM_K    = 5'b10001;
    localparam logic [4:0] SYM_T    = 5'b01101;
    localparam logic [4:0] SYM_R    = 5'b00111;

    // PRBS7 polynomial x^7 + x^6 + 1: feedback is p[6] ^ p[5].
    localparam int PRBS7_TAP_HI = 6;
    localparam int PRBS7_TAP_LO = 5;

    // 4b5b data symbol for one nibble.
    function automatic logic [4:0] enc_4b5b(input logic [3:0] nibble);
        logic [4:0] sym;
        case (nibble)
            4'h0:    sym = 5'b11110;
            4'h1:    sym = 5'b01001;
            4'h2:    sym = 5'b10100;
            4'h3:    sym = 5'b10101;
            4'h4:    sym = 5'b01010;
            4'h5:    sym = 5'b01011;
            4'h6:    sym = 5'b01110;
            4'h7:    sym = 5'b01111;
            4'h8:    sym = 5'b10010;
            4'h9:    sym = 5'b10011;
            4'hA:    sym = 5'b10110;
            4'hB:    sym = 5'b10111;
            4'hC:    sym = 5'b11010;
            4'hD:    sym = 5'b11011;
            4'hE:    sym = 5'b11100;
            default: sym = 5'b11101;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/serdesphy_prbs7_gen.sv
// ----------------------------------------------------------------------------
// serdesphy_prbs7_gen
//   PRBS7 (x^7 + x^6 + 1) LFSR. bit_out is the bit produced by the next
//   advance; the register steps only when advance is high, so the sequence
//   position is kept while the generator is not in use.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (LFSR <= SEED)
//   advance  in   step the LFSR this cycle
//   bit_out  out  new PRBS bit for the current/next step
// ----------------------------------------------------------------------------
module serdesphy_prbs7_gen
    import serdesphy_pcs_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    output logic bit_out
);

    logic [6:0] r_lfsr;

    assign bit_out = r_lfsr[PRBS7_TAP_HI] ^ r_lfsr[PRBS7_TAP_LO];

    // The SEED must be non-zero or the LFSR locks up at all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= {r_lfsr[5:0], bit_out};
        end
    end

endmodule

// File: rtl/serdesphy_tx_framer.sv
// ----------------------------------------------------------------------------
// serdesphy_tx_framer
//   TX line-coding stage. Pops nibbles from a FWFT FIFO, 4b5b-encodes them and
//   frames each burst as J K <data...> T R, filling gaps with IDLE symbols.
//   Alternatively streams raw PRBS7. One bit leaves per serializer-ready cycle.
//
// Ports
//   clk_240m_tx       in   TX bit clock
//   rst_n_240m_tx     in   asynchronous active-low reset
//   tx_en             in   framer enable; dropping it mid-burst flags tx_error
//   tx_idle           in   force idle; an open burst is closed with T R
//   tx_data_sel       in   0 = FIFO data, 1 = PRBS7
//   serializer_ready  in   advance enable; everything holds when low
//   fifo_data[3:0]    in   FIFO head nibble
//   fifo_empty        in   FIFO empty flag
//   fifo_rd_en        out  pop strobe, one per nibble consumed
//   tx_serial_data    out  serial bit (symbol MSB first)
//   tx_serial_valid   out  serial bit valid
//   tx_idle_pattern   out  symbol on the line is IDLE
//   tx_active         out  burst or PRBS in progress
//   tx_error          out  sticky: burst aborted by tx_en deassertion
// ----------------------------------------------------------------------------
module serdesphy_tx_framer
    import serdesphy_pcs_pkg::*;
#(
    parameter logic [6:0] PRBS_SEED = 7'h7F,
    parameter int         SYM_W     = 5
) (
    input  logic       clk_240m_tx,
    input  logic       rst_n_240m_tx,
    input  logic       tx_en,
    input  logic       tx_idle,
    input  logic       tx_data_sel,
    input  logic       serializer_ready,
    input  logic [3:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       tx_serial_data,
    output logic       tx_serial_valid,
    output logic       tx_idle_pattern,
    output logic       tx_active,
    output logic       tx_error
);

    tx_state_e        r_state;
    logic [SYM_W-1:0] r_shreg;
    logic [2:0]       r_bit_cnt;
    logic             r_tx_error;

    tx_state_e        w_state_nxt;
    logic [SYM_W-1:0] w_shreg_nxt;
    logic [2:0]       w_bit_cnt_nxt;
    logic             w_tx_error_nxt;
    logic             w_rd_en;
    logic             w_prbs_adv;
    logic             w_prbs_bit;
    logic             w_boundary;
    logic             w_can_pop;
    logic             w_in_burst;

    serdesphy_prbs7_gen #(
        .SEED (PRBS_SEED)
    ) u_prbs (
        .clk     (clk_240m_tx),
        .rst_n   (rst_n_240m_tx),
        .advance (w_prbs_adv),
        .bit_out (w_prbs_bit)
    );

    // DISABLED has no symbol in flight, so every advance there is a boundary.
    assign w_boundary = (r_bit_cnt == 3'd4) || (r_state == ST_DISABLED);
    assign w_can_pop  = !tx_idle && !fifo_empty;
    assign w_in_burst = r_state inside {ST_SSD_J, ST_SSD_K, ST_DATA, ST_ESD_T, ST_ESD_R};

    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx) begin
            r_state    <= ST_DISABLED;
            r_shreg    <= '0;
            r_bit_cnt  <= 3'd0;
            r_tx_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_error <= w_tx_error_nxt;
        end
    end

    // tx_en = 0 wins over serializer_ready so the line shuts off immediately.
    // PRBS mode emits a fresh LFSR bit on every advance and ignores bit_cnt;
    // entering it from IDLE already produces the first PRBS bit.
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_error_nxt = r_tx_error;
        w_rd_en        = 1'b0;
        w_prbs_adv     = 1'b0;

        if (!tx_en) begin
            w_state_nxt   = ST_DISABLED;
            w_shreg_nxt   = '0;
            w_bit_cnt_nxt = 3'd0;
            if (w_in_burst) begin
                w_tx_error_nxt = 1'b1;
            end
        end else if (serializer_ready) begin
            if (r_state == ST_PRBS) begin
                w_bit_cnt_nxt = 3'd0;
                if (tx_data_sel && !tx_idle) begin
                    w_prbs_adv  = 1'b1;
                    w_shreg_nxt = {w_prbs_bit, {(SYM_W-1){1'b0}}};
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_shreg_nxt = SYM_IDLE;
                end
            end else if (w_boundary) begin
                w_bit_cnt_nxt = 3'd0;
                case (r_state)
                    ST_DISABLED: begin
                        w_state_nxt = ST_IDLE;
                        w_shreg_nxt = SYM_IDLE;
                    end
                    ST_IDLE: begin
                        if (tx_data_sel) begin
                            w_state_nxt = ST_PRBS;
                            w_prbs_adv  = 1'b1;
                            w_shreg_nxt = {w_prbs_bit, {(SYM_W-1){1'b0}}};
                        end else if (w_can_pop) begin
                            w_state_nxt = ST_SSD_J;
                            w_shreg_nxt = SYM_J;
                        end else begin
                            w_shreg_nxt = SYM_IDLE;
                        end
                    end
                    ST_SSD_J: begin
                        w_state_nxt = ST_SSD_K;
                        w_shreg_nxt = SYM_K;
                    end
                    ST_SSD_K, ST_DATA: begin
                        if (w_can_pop) begin
                            w_state_nxt = ST_DATA;
                            w_shreg_nxt = enc_4b5b(fifo_data);
                            w_rd_en     = 1'b1;
                        end else begin
                            w_state_nxt = ST_ESD_T;
                            w_shreg_nxt = SYM_T;
                        end
                    end
                    ST_ESD_T: begin
                        w_state_nxt = ST_ESD_R;
                        w_shreg_nxt = SYM_R;
                    end
                    ST_ESD_R: begin
                        w_state_nxt = ST_IDLE;
                        w_shreg_nxt = SYM_IDLE;
                    end
                    default: begin
                        w_state_nxt = ST_DISABLED;
                        w_shreg_nxt = '0;
                    end
                endcase
            end else begin
                w_shreg_nxt   = r_shreg << 1;
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
        end
    end

    // Every flag follows the state register, so all of them hold with it.
    assign fifo_rd_en      = w_rd_en;
    assign tx_serial_data  = r_shreg[SYM_W-1];
    assign tx_serial_valid = (r_state != ST_DISABLED);
    assign tx_idle_pattern = (r_state == ST_IDLE);
    assign tx_active       = w_in_burst || (r_state == ST_PRBS);
    assign tx_error        = r_tx_error;

endmodule
